// File: rtl/buffer_seq.sv
// buffer_seq: loads a job of vectors into an external buffer, then replays
// the buffered vectors a programmable number of times on an output stream.
//
// Ports:
//   i_clk, i_rst          clock (rising edge), async active-high reset
//   i_start, i_abort      job start (IDLE only), job cancel
//   i_len, i_reps         vectors per job, full read-out passes
//   i_in_valid/o_in_ready/i_in_data      load stream
//   o_buf_we/o_buf_addr_wr/o_buf_data_wr buffer write port
//   o_buf_addr_rd/i_buf_data_rd          buffer read port (comb. read)
//   o_out_valid/i_out_ready/o_out_data   output stream
//   o_busy                high in LOAD or DRAIN
//   o_done                one-cycle job-complete pulse
module buffer_seq #(
    parameter int VEC_WIDTH  = 384,
    parameter int ARR_DEPTH  = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int REP_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH:0]   i_len,
    input  logic [REP_WIDTH-1:0]  i_reps,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [VEC_WIDTH-1:0]  i_in_data,
    output logic                  o_buf_we,
    output logic [ADDR_WIDTH-1:0] o_buf_addr_wr,
    output logic [VEC_WIDTH-1:0]  o_buf_data_wr,
    output logic [ADDR_WIDTH-1:0] o_buf_addr_rd,
    input  logic [VEC_WIDTH-1:0]  i_buf_data_rd,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [VEC_WIDTH-1:0]  o_out_data,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH =
        (ADDR_WIDTH+1)'(ARR_DEPTH);
    localparam logic [ADDR_WIDTH:0] LEN_ONE =
        (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE =
        ADDR_WIDTH'(1);
    localparam logic [REP_WIDTH-1:0] REP_ONE =
        REP_WIDTH'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [REP_WIDTH-1:0]  reps_q, reps_d;
    logic [REP_WIDTH-1:0]  rep_cnt_q, rep_cnt_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic                  done_q, done_d;

    logic [ADDR_WIDTH:0]   len_clamp;
    logic [REP_WIDTH-1:0]  reps_clamp;
    logic                  load_hs;
    logic                  out_hs;
    logic                  wr_last;
    logic                  rd_last;
    logic                  rep_last;

    assign len_clamp  = (i_len > DEPTH) ? DEPTH : i_len;
    assign reps_clamp = (i_reps == '0) ? REP_ONE : i_reps;

    assign load_hs  = (state_q == LOAD) && i_in_valid;
    assign out_hs   = (state_q == DRAIN) && i_out_ready;
    assign wr_last  = ({1'b0, wr_ptr_q} == (len_q - LEN_ONE));
    assign rd_last  = ({1'b0, rd_ptr_q} == (len_q - LEN_ONE));
    assign rep_last = (rep_cnt_q == (reps_q - REP_ONE));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            reps_q    <= '0;
            rep_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            reps_q    <= reps_d;
            rep_cnt_q <= rep_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        reps_d    = reps_q;
        rep_cnt_d = rep_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start && !i_abort) begin
                    len_d     = len_clamp;
                    reps_d    = reps_clamp;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    rep_cnt_d = '0;
                    // An empty job completes without leaving IDLE.
                    if (len_clamp == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (load_hs) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    if (wr_last) begin
                        state_d   = DRAIN;
                        rd_ptr_d  = '0;
                        rep_cnt_d = '0;
                    end
                end
                // The handshake above still lands; only the state is cut.
                if (i_abort) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (out_hs) begin
                    if (!rd_last) begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                    end else if (!rep_last) begin
                        rd_ptr_d  = '0;
                        rep_cnt_d = rep_cnt_q + REP_ONE;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                // A cancelled job never reports completion.
                if (i_abort) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_in_ready    = (state_q == LOAD);
    assign o_buf_we      = load_hs;
    assign o_buf_addr_wr = wr_ptr_q;
    assign o_buf_data_wr = i_in_data;
    assign o_buf_addr_rd = (state_q == DRAIN) ? rd_ptr_q : '0;
    assign o_out_valid   = (state_q == DRAIN);
    assign o_out_data    = i_buf_data_rd;
    assign o_busy        = (state_q == LOAD) || (state_q == DRAIN);
    assign o_done        = done_q;

endmodule

// File: tb/tb_buffer_seq.sv
// tb_buffer_seq: directed bench for buffer_seq with a buffer model and an
// output scoreboard.
module tb_buffer_seq;

    localparam int VW = 384;
    localparam int AW = 4;
    localparam int RW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic          i_abort;
    logic [AW:0]   i_len;
    logic [RW-1:0] i_reps;
    logic          i_in_valid;
    logic          o_in_ready;
    logic [VW-1:0] i_in_data;
    logic          o_buf_we;
    logic [AW-1:0] o_buf_addr_wr;
    logic [VW-1:0] o_buf_data_wr;
    logic [AW-1:0] o_buf_addr_rd;
    logic [VW-1:0] i_buf_data_rd;
    logic          o_out_valid;
    logic          i_out_ready;
    logic [VW-1:0] o_out_data;
    logic          o_busy;
    logic          o_done;

    buffer_seq dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_len         (i_len),
        .i_reps        (i_reps),
        .i_in_valid    (i_in_valid),
        .o_in_ready    (o_in_ready),
        .i_in_data     (i_in_data),
        .o_buf_we      (o_buf_we),
        .o_buf_addr_wr (o_buf_addr_wr),
        .o_buf_data_wr (o_buf_data_wr),
        .o_buf_addr_rd (o_buf_addr_rd),
        .i_buf_data_rd (i_buf_data_rd),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_out_data    (o_out_data),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 i_clk = ~i_clk;

    logic [VW-1:0] mem [16];
    always @(posedge i_clk) begin
        if (o_buf_we) mem[o_buf_addr_wr] <= o_buf_data_wr;
    end
    assign i_buf_data_rd = mem[o_buf_addr_rd];

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int exp_done_cnt = 0;
    logic [VW-1:0] exp_q [$];
    logic [VW-1:0] words [16];
    logic          prev_stall = 1'b0;
    logic [VW-1:0] held;
    logic          exp_done = 1'b0;

    task automatic chk(string tag, logic [VW-1:0] obs,
                       logic [VW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output scoreboard, stall stability and done-timing checks.
    always @(negedge i_clk) begin
        if (i_rst) begin
            prev_stall = 1'b0;
            exp_done   = 1'b0;
        end else begin
            if (o_done) done_cnt++;
            if (exp_done) chk("done_timing", VW'(o_done), VW'(1));
            exp_done = 1'b0;
            if (prev_stall) chk("stall_hold", o_out_data, held);
            prev_stall = 1'b0;
            if (o_out_valid && i_out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", VW'(1), VW'(0));
                end else begin
                    chk("out_data", o_out_data, exp_q.pop_front());
                    if (exp_q.size() == 0 && !i_abort) exp_done = 1'b1;
                end
            end else if (o_out_valid) begin
                prev_stall = 1'b1;
                held       = o_out_data;
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_job(int len, int reps);
        i_start = 1'b1;
        i_len   = (AW+1)'(len);
        i_reps  = RW'(reps);
        step();
        i_start = 1'b0;
    endtask

    task automatic run_load(int n);
        logic [VW-1:0] w;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 12; j++) w[j*32 +: 32] = $urandom;
            words[k]   = w;
            i_in_data  = w;
            i_in_valid = 1'b1;
            #2;
            chk("buf_we", VW'(o_buf_we), VW'(1));
            chk("buf_addr_wr", VW'(o_buf_addr_wr), VW'(k));
            chk("buf_data_wr", o_buf_data_wr, w);
            step();
        end
        i_in_valid = 1'b0;
    endtask

    task automatic push_exp(int n, int reps);
        for (int r = 0; r < reps; r++)
            for (int k = 0; k < n; k++) exp_q.push_back(words[k]);
    endtask

    task automatic wait_done(int budget, bit tog);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (tog) i_out_ready = ~i_out_ready;
            @(negedge i_clk);
            got = o_done;
            step();
        end
        i_out_ready = 1'b1;
        chk("done_seen", VW'(got), VW'(1));
        chk("queue_empty", VW'(exp_q.size()), VW'(0));
    endtask

    initial begin
        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_abort     = 1'b0;
        i_len       = '0;
        i_reps      = '0;
        i_in_valid  = 1'b1;
        i_in_data   = '0;
        i_out_ready = 1'b1;
        #2;
        chk("rst_busy", VW'(o_busy), VW'(0));
        chk("rst_in_ready", VW'(o_in_ready), VW'(0));
        chk("rst_buf_we", VW'(o_buf_we), VW'(0));
        chk("rst_out_valid", VW'(o_out_valid), VW'(0));
        chk("rst_addr_rd", VW'(o_buf_addr_rd), VW'(0));
        chk("rst_done", VW'(o_done), VW'(0));
        step();
        i_rst      = 1'b0;
        i_in_valid = 1'b0;
        step();

        // Basic job: 4 vectors, 2 passes.
        start_job(4, 2);
        chk("b_busy", VW'(o_busy), VW'(1));
        chk("b_in_ready", VW'(o_in_ready), VW'(1));
        run_load(4);
        push_exp(4, 2);
        chk("b_drain_valid", VW'(o_out_valid), VW'(1));
        chk("b_drain_in_ready", VW'(o_in_ready), VW'(0));
        wait_done(40, 1'b0);
        exp_done_cnt++;
        chk("b_done_cnt", VW'(done_cnt), VW'(exp_done_cnt));
        chk("b_idle_busy", VW'(o_busy), VW'(0));

        // Backpressure: 3 vectors, 1 pass, ready toggling.
        start_job(3, 1);
        run_load(3);
        push_exp(3, 1);
        wait_done(40, 1'b1);
        exp_done_cnt++;
        chk("bp_done_cnt", VW'(done_cnt), VW'(exp_done_cnt));

        // Clamping: 20 requested, depth 16, zero reps -> one pass.
        start_job(20, 0);
        run_load(16);
        push_exp(16, 1);
        chk("cl_in_ready", VW'(o_in_ready), VW'(0));
        wait_done(60, 1'b0);
        exp_done_cnt++;
        chk("cl_done_cnt", VW'(done_cnt), VW'(exp_done_cnt));

        // Zero length: done next cycle, never busy.
        start_job(0, 1);
        chk("z_busy", VW'(o_busy), VW'(0));
        chk("z_done", VW'(o_done), VW'(1));
        step();
        chk("z_done_low", VW'(o_done), VW'(0));
        chk("z_busy2", VW'(o_busy), VW'(0));
        exp_done_cnt++;

        // Abort after 2 of 4 loads.
        start_job(4, 1);
        run_load(2);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        chk("ab_busy", VW'(o_busy), VW'(0));
        chk("ab_in_ready", VW'(o_in_ready), VW'(0));
        step();
        step();
        chk("ab_no_done", VW'(done_cnt), VW'(exp_done_cnt));
        start_job(2, 1);
        run_load(2);
        push_exp(2, 1);
        wait_done(20, 1'b0);
        exp_done_cnt++;
        chk("ab_next_done", VW'(done_cnt), VW'(exp_done_cnt));

        // Reset in the middle of DRAIN.
        start_job(3, 3);
        run_load(3);
        push_exp(3, 3);
        step();
        step();
        i_rst = 1'b1;
        #1;
        chk("mr_out_valid", VW'(o_out_valid), VW'(0));
        chk("mr_busy", VW'(o_busy), VW'(0));
        chk("mr_addr_rd", VW'(o_buf_addr_rd), VW'(0));
        exp_q.delete();
        step();
        i_rst = 1'b0;
        step();
        step();
        chk("mr_no_done", VW'(done_cnt), VW'(exp_done_cnt));
        start_job(4, 1);
        run_load(4);
        push_exp(4, 1);
        wait_done(30, 1'b0);
        exp_done_cnt++;
        chk("mr_done_cnt", VW'(done_cnt), VW'(exp_done_cnt));

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
